// File: rtl/detector_scheduler.sv
// detector_scheduler: a single sequence-detection datapath shared by NCH
// serial bit streams. A round-robin arbiter picks one pending channel per
// cycle. That channel's saved context (shift history plus a saturating fill
// count) is advanced by one bit and written back. A match is reported with
// the channel number one cycle after the completing bit is accepted.
//
// Optional feature macro: DETSCHED_FLUSH_EN
//   defined   -> a per-channel flush port exists. It clears that channel's
//                context and removes the channel from arbitration for the
//                cycle in which flush is high.
//   undefined -> there is no flush port. Contexts clear only on reset.
module detector_scheduler #(
    parameter int             NCH     = 4,
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic [NCH-1:0]             in_bit,
    input  logic [NCH-1:0]             in_valid,
`ifdef DETSCHED_FLUSH_EN
    input  logic [NCH-1:0]             flush,
`endif
    output logic [NCH-1:0]             in_ready,
    output logic                       match_valid,
    output logic [$clog2(NCH)-1:0]     match_ch
);

    localparam int CHW = $clog2(NCH);
    localparam int FW  = $clog2(LEN + 1);

    // Saturating fill counter: counts accepted bits, stops at LEN.
    function automatic logic [FW-1:0] fill_inc(input logic [FW-1:0] f);
        return (f >= FW'(LEN)) ? FW'(LEN) : f + 1'b1;
    endfunction

    // Next round-robin pointer: the channel after the granted one, wrapping at NCH.
    function automatic logic [CHW-1:0] ptr_after(input logic [CHW-1:0] g);
        return (g == CHW'(NCH - 1)) ? '0 : g + 1'b1;
    endfunction

    logic [LEN-1:0] hist_q [NCH];
    logic [FW-1:0]  fill_q [NCH];
    logic [CHW-1:0] ptr_q, ptr_d;
    logic           match_valid_q, match_valid_d;
    logic [CHW-1:0] match_ch_q, match_ch_d;

    logic [NCH-1:0] flush_w;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] grant;
    logic [CHW-1:0] gnt_ch;
    logic           xfer;
    logic [CHW:0]   idx_w;
    logic [LEN-1:0] new_hist;
    logic           full;
    logic           hit;

`ifdef DETSCHED_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = '0;
`endif

    // A channel being flushed is invisible to the arbiter for that cycle.
    assign elig = in_valid & ~flush_w;

    // Round-robin search from ptr_q; the first eligible channel wins the grant.
    always_comb begin
        grant  = '0;
        gnt_ch = '0;
        xfer   = 1'b0;
        idx_w  = '0;
        for (int k = 0; k < NCH; k++) begin
            idx_w = {1'b0, ptr_q} + (CHW+1)'(k);
            if (idx_w >= (CHW+1)'(NCH)) begin
                idx_w = idx_w - (CHW+1)'(NCH);
            end
            if (!xfer && elig[idx_w[CHW-1:0]]) begin
                xfer   = 1'b1;
                gnt_ch = idx_w[CHW-1:0];
            end
        end
        grant[gnt_ch] = xfer;
    end

    assign in_ready = grant;

    // Restore the granted channel's context, shift in its bit, and test for a match.
    always_comb begin
        new_hist      = {hist_q[gnt_ch][LEN-2:0], in_bit[gnt_ch]};
        full          = (fill_q[gnt_ch] >= FW'(LEN - 1));
        hit           = xfer && full && (new_hist == PATTERN);
        ptr_d         = xfer ? ptr_after(gnt_ch) : ptr_q;
        match_valid_d = hit;
        match_ch_d    = xfer ? gnt_ch : match_ch_q;
    end

    // Write back the per-channel context table: flush clears, a grant advances.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                hist_q[c] <= '0;
                fill_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (flush_w[c]) begin
                    hist_q[c] <= '0;
                    fill_q[c] <= '0;
                end else if (xfer && (gnt_ch == CHW'(c))) begin
                    hist_q[c] <= new_hist;
                    fill_q[c] <= fill_inc(fill_q[c]);
                end
            end
        end
    end

    // Arbiter pointer and registered match report.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            ptr_q         <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;

endmodule
